// File: rtl/uart_alu_interface_if.sv
// Byte/handshake bundle between the command decoder and its uart_rx, uart_tx and ALU neighbours.
// The slave modport is the decoder's view; master is the surrounding top (or a bench).
interface uart_alu_interface_if #(
   parameter int NB_DATA = 8,
   parameter int NB_OPS  = 6
);
   logic [NB_DATA-1:0] rx_data;
   logic               rx_done;
   logic [NB_DATA-1:0] alu_result;
   logic               tx_done;
   logic [NB_DATA-1:0] data_a;
   logic [NB_DATA-1:0] data_b;
   logic [NB_OPS-1:0]  op;
   logic [NB_DATA-1:0] tx_data;
   logic               tx_start;
   logic               busy;

   modport slave (
      input  rx_data, rx_done, alu_result, tx_done,
      output data_a, data_b, op, tx_data, tx_start, busy
   );

   modport master (
      output rx_data, rx_done, alu_result, tx_done,
      input  data_a, data_b, op, tx_data, tx_start, busy
   );
endinterface

// File: rtl/uart_alu_interface.sv
// Command decoder: location/value writes into ALU operand registers, GET sends the ALU result to uart_tx.
//
//  state      | meaning
//  -----------+----------------------------------------------------------
//  IDLE       | waiting for a command byte (location code or GET)
//  WAIT_VALUE | location latched, next received byte is data
//  SEND       | one cycle: capture ALU result, raise tx_start
//  WAIT_TX    | frame in flight, waiting for tx_done
module uart_alu_interface #(
   parameter int NB_DATA = 8,
   parameter int NB_OPS  = 6
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   uart_alu_interface_if.slave   bus
);

   localparam logic [NB_DATA-1:0] CODE_A   = NB_DATA'(8'h00);
   localparam logic [NB_DATA-1:0] CODE_B   = NB_DATA'(8'h01);
   localparam logic [NB_DATA-1:0] CODE_OP  = NB_DATA'(8'h02);
   localparam logic [NB_DATA-1:0] CODE_GET = {NB_DATA{1'b1}};

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_VALUE = 2'd1,
      SEND       = 2'd2,
      WAIT_TX    = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      LOC_A  = 2'd0,
      LOC_B  = 2'd1,
      LOC_OP = 2'd2
   } loc_t;

   state_t             state_q, state_d;
   loc_t               loc_q, loc_d;
   logic [NB_DATA-1:0] data_a_q, data_a_d;
   logic [NB_DATA-1:0] data_b_q, data_b_d;
   logic [NB_OPS-1:0]  op_q, op_d;
   logic [NB_DATA-1:0] tx_data_q, tx_data_d;
   logic               tx_start_q, tx_start_d;
   logic               busy_q, busy_d;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= IDLE;
         loc_q      <= LOC_A;
         data_a_q   <= '0;
         data_b_q   <= '0;
         op_q       <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         loc_q      <= loc_d;
         data_a_q   <= data_a_d;
         data_b_q   <= data_b_d;
         op_q       <= op_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      loc_d      = loc_q;
      data_a_d   = data_a_q;
      data_b_d   = data_b_q;
      op_d       = op_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.rx_done) begin
               if (bus.rx_data == CODE_A) begin
                  loc_d   = LOC_A;
                  state_d = WAIT_VALUE;
               end else if (bus.rx_data == CODE_B) begin
                  loc_d   = LOC_B;
                  state_d = WAIT_VALUE;
               end else if (bus.rx_data == CODE_OP) begin
                  loc_d   = LOC_OP;
                  state_d = WAIT_VALUE;
               end else if (bus.rx_data == CODE_GET) begin
                  state_d = SEND;
               end
            end
         end
         // The value byte is raw data even when it matches a command code.
         WAIT_VALUE: begin
            if (bus.rx_done) begin
               case (loc_q)
                  LOC_A:   data_a_d = bus.rx_data;
                  LOC_B:   data_b_d = bus.rx_data;
                  LOC_OP:  op_d     = bus.rx_data[NB_OPS-1:0];
                  default: ;
               endcase
               state_d = IDLE;
            end
         end
         SEND: begin
            tx_data_d  = bus.alu_result;
            tx_start_d = 1'b1;
            state_d    = WAIT_TX;
         end
         WAIT_TX: begin
            if (bus.tx_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   assign bus.data_a   = data_a_q;
   assign bus.data_b   = data_b_q;
   assign bus.op       = op_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.tx_start = tx_start_q;
   assign bus.busy     = busy_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench for uart_alu_interface: drive on the falling edge, check just before the next drive.
module tb_uart_alu_interface;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   uart_alu_interface_if #(.NB_DATA(8), .NB_OPS(6)) bus ();

   uart_alu_interface #(.NB_DATA(8), .NB_OPS(6)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic rx_byte(input logic [7:0] b);
      @(negedge clk);
      bus.rx_data = b;
      bus.rx_done = 1'b1;
      @(negedge clk);
      bus.rx_done = 1'b0;
   endtask

   task automatic tx_finish();
      @(negedge clk);
      bus.tx_done = 1'b1;
      @(negedge clk);
      bus.tx_done = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_regs(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [5:0] op);
      check({tag, ".a"},  32'(bus.data_a), 32'(a));
      check({tag, ".b"},  32'(bus.data_b), 32'(b));
      check({tag, ".op"}, 32'(bus.op),     32'(op));
   endtask

   task automatic check_all_zero(input string tag);
      check_regs(tag, 8'h00, 8'h00, 6'h00);
      check({tag, ".tx_data"},  32'(bus.tx_data),  32'h0);
      check({tag, ".tx_start"}, 32'(bus.tx_start), 32'h0);
      check({tag, ".busy"},     32'(bus.busy),     32'h0);
   endtask

   initial begin
      n_checks       = 0;
      n_errors       = 0;
      rst            = 1'b1;
      bus.rx_data    = 8'h00;
      bus.rx_done    = 1'b0;
      bus.alu_result = 8'h00;
      bus.tx_done    = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_all_zero("reset");

      // 1: write A
      rx_byte(8'h00);
      check("t1.busy_wait_value", 32'(bus.busy), 32'h1);
      rx_byte(8'h4F);
      check_regs("t1", 8'h4F, 8'h00, 6'h00);
      check("t1.busy_idle", 32'(bus.busy), 32'h0);

      // 2: write B and OP, OP upper bits discarded
      rx_byte(8'h01); rx_byte(8'h10);
      rx_byte(8'h02); rx_byte(8'h20);
      check_regs("t2", 8'h4F, 8'h10, 6'h20);
      rx_byte(8'h02); rx_byte(8'hE0);
      check("t2.op_trunc", 32'(bus.op), 32'h20);
      rx_byte(8'h02); rx_byte(8'h3F);
      check("t2.op_max", 32'(bus.op), 32'h3F);

      // 3: GET timing; rx_byte returns at the falling edge inside cycle n+1 (state SEND)
      bus.alu_result = 8'h5F;
      rx_byte(8'hFF);
      check("t3.start_n1", 32'(bus.tx_start), 32'h0);
      check("t3.busy_n1",  32'(bus.busy),     32'h1);
      @(negedge clk);
      check("t3.start_n2", 32'(bus.tx_start), 32'h1);
      check("t3.tx_data",  32'(bus.tx_data),  32'h5F);
      bus.alu_result = 8'hA5;
      @(negedge clk);
      check("t3.start_n3", 32'(bus.tx_start), 32'h0);
      check("t3.busy_n3",  32'(bus.busy),     32'h1);
      repeat (4) @(negedge clk);
      check("t3.busy_wait", 32'(bus.busy),    32'h1);
      check("t3.tx_hold",   32'(bus.tx_data), 32'h5F);
      tx_finish();
      check("t3.busy_done", 32'(bus.busy), 32'h0);
      check_regs("t3", 8'h4F, 8'h10, 6'h3F);

      // 4: invalid command ignored; 0xFF as value is data
      rx_byte(8'h7A);
      check("t4.busy_invalid", 32'(bus.busy), 32'h0);
      check_regs("t4.invalid", 8'h4F, 8'h10, 6'h3F);
      rx_byte(8'h01);
      rx_byte(8'hFF);
      check("t4.b_ff", 32'(bus.data_b), 32'hFF);
      check("t4.busy", 32'(bus.busy), 32'h0);
      @(negedge clk);
      check("t4.no_start", 32'(bus.tx_start), 32'h0);
      check("t4.tx_data_hold", 32'(bus.tx_data), 32'h5F);

      // 5: bytes dropped while transmitting, incl. same-cycle tx_done
      rx_byte(8'hFF);
      @(negedge clk);
      check("t5.start", 32'(bus.tx_start), 32'h1);
      check("t5.tx_data", 32'(bus.tx_data), 32'hA5);
      rx_byte(8'h00);
      rx_byte(8'h33);
      check("t5.busy_still", 32'(bus.busy), 32'h1);
      tx_finish();
      check("t5.busy_done", 32'(bus.busy), 32'h0);
      check("t5.a_kept", 32'(bus.data_a), 32'h4F);
      rx_byte(8'hFF);
      @(negedge clk);
      @(negedge clk);
      bus.rx_data = 8'h00;
      bus.rx_done = 1'b1;
      bus.tx_done = 1'b1;
      @(negedge clk);
      bus.rx_done = 1'b0;
      bus.tx_done = 1'b0;
      check("t5.simul_idle", 32'(bus.busy), 32'h0);
      rx_byte(8'h44);
      check("t5.simul_dropped_busy", 32'(bus.busy), 32'h0);
      check("t5.simul_dropped_a", 32'(bus.data_a), 32'h4F);

      // 6: reset mid-command
      rx_byte(8'h00);
      check("t6.busy_wv", 32'(bus.busy), 32'h1);
      pulse_reset();
      check_all_zero("t6.rst_wv");
      rx_byte(8'h01); rx_byte(8'h22);
      bus.alu_result = 8'h77;
      rx_byte(8'hFF);
      repeat (2) @(negedge clk);
      check("t6.busy_wtx", 32'(bus.busy), 32'h1);
      pulse_reset();
      check_all_zero("t6.rst_wtx");
      rx_byte(8'h33);
      check("t6.busy_33", 32'(bus.busy), 32'h0);
      check_regs("t6.after_33", 8'h00, 8'h00, 6'h00);
      rx_byte(8'h00); rx_byte(8'h11);
      check_regs("t6.final", 8'h11, 8'h00, 6'h00);
      check("t6.busy_final", 32'(bus.busy), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
